// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the EX stage. It owns HI/LO and stalls the pipe while
// MULT/MULTU/DIV/DIVU iterate; MTHI/MTLO complete in a single cycle.
module ex_muldiv_unit #(
  parameter int unsigned       DATA_W    = 32,
  parameter logic [DATA_W-1:0] DIV0_QUOT = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              stallreq,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  state_e              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   mcand;
  logic                neg_q;
  logic                neg_r;
  logic                is_div;
  logic                div0;
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                is_mul_op, is_div_op, is_signed_op;
  logic                accept, accept_md, div_zero;
  logic                src1_neg, src2_neg;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_nx;
  logic [DATA_W:0]     div_shift, div_diff;
  logic                div_ge;
  logic [DATA_W-1:0]   div_rem;
  logic [2*DATA_W-1:0] div_nx;
  logic [DATA_W-1:0]   quot, rem;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   res_hi, res_lo;
  logic                commit;

  always_comb begin
    is_mul_op    = (op == OP_MULT) || (op == OP_MULTU);
    is_div_op    = (op == OP_DIV)  || (op == OP_DIVU);
    is_signed_op = (op == OP_MULT) || (op == OP_DIV);
    accept       = (state == S_IDLE) && start && !flush;
    accept_md    = accept && (is_mul_op || is_div_op);
    div_zero     = is_div_op && (src2 == '0);
    src1_neg     = is_signed_op && src1[DATA_W-1];
    src2_neg     = is_signed_op && src2[DATA_W-1];
    mag1         = src1_neg ? -src1 : src1;
    mag2         = src2_neg ? -src2 : src2;
  end

  // Shift-add: upper half accumulates the multiplicand, multiplier bits retire from the bottom.
  always_comb begin
    mul_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mcand} : '0);
    mul_nx  = {mul_sum, prod[DATA_W-1:1]};
  end

  // Restoring division: upper half is the partial remainder, lower half shifts dividend out
  // and quotient bits in.
  always_comb begin
    div_shift = {prod[2*DATA_W-1:DATA_W], prod[DATA_W-1]};
    div_diff  = div_shift - {1'b0, mcand};
    div_ge    = div_shift >= {1'b0, mcand};
    div_rem   = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    div_nx    = {div_rem, prod[DATA_W-2:0], div_ge};
  end

  always_comb begin
    quot     = prod[DATA_W-1:0];
    rem      = prod[2*DATA_W-1:DATA_W];
    prod_fix = neg_q ? -prod : prod;
    if (div0) begin
      res_hi = prod[DATA_W-1:0];
      res_lo = DIV0_QUOT;
    end else if (is_div) begin
      res_hi = neg_r ? -rem : rem;
      res_lo = neg_q ? -quot : quot;
    end else begin
      res_hi = prod_fix[2*DATA_W-1:DATA_W];
      res_lo = prod_fix[DATA_W-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept_md) begin
          if (is_mul_op)     state_nx = S_MUL;
          else if (div_zero) state_nx = S_DONE;
          else               state_nx = S_DIV;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)                 state_nx = S_IDLE;
        else if (cnt == LAST_ITER) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The result is visible on hi/lo during DONE and committed at its end, so a flush
  // arriving in DONE still leaves HI/LO untouched and suppresses the done pulse.
  always_comb begin
    commit   = (state == S_DONE) && !flush;
    done     = commit;
    hi       = commit ? res_hi : hi_q;
    lo       = commit ? res_lo : lo_q;
    stallreq = ((state == S_IDLE) && start && (is_mul_op || is_div_op)) ||
               (state == S_MUL) || (state == S_DIV);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept && (op == OP_MTHI)) hi_q <= src1;
          if (accept && (op == OP_MTLO)) lo_q <= src1;
          if (accept_md) begin
            cnt    <= '0;
            mcand  <= is_mul_op ? mag1 : mag2;
            neg_q  <= src1_neg ^ src2_neg;
            neg_r  <= src1_neg;
            is_div <= is_div_op;
            div0   <= div_zero;
            if (is_mul_op)     prod <= {{DATA_W{1'b0}}, mag2};
            else if (div_zero) prod <= {{DATA_W{1'b0}}, src1};
            else               prod <= {{DATA_W{1'b0}}, mag1};
          end
        end
        S_MUL: begin
          prod <= mul_nx;
          cnt  <= cnt + CNT_W'(1);
        end
        S_DIV: begin
          prod <= div_nx;
          cnt  <= cnt + CNT_W'(1);
        end
        S_DONE: begin
          cnt <= '0;
          if (commit) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit (DATA_W=32): latency, signed/unsigned results,
// divide-by-zero, MTHI/MTLO, flush and mid-operation reset.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic        stallreq, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [2:0] MULT = 3'd1, MULTU = 3'd2, DIV = 3'd3, DIVU = 3'd4,
                         MTHI = 3'd5, MTLO = 3'd6;

  ex_muldiv_unit #(.DATA_W(32), .DIV0_QUOT(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .src1(src1), .src2(src2), .stallreq(stallreq), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a mul/div op in the current cycle; lat is the number of stall cycles after accept.
  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stalls = 0;
    int early  = 0;
    start = 1'b1; op = o; src1 = a; src2 = b;
    @(negedge clk);
    if (stallreq) stalls++;
    next_cycle();
    start = 1'b0; op = 3'd0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (stallreq) stalls++;
      if (done) early++;
    end
    check_val($sformatf("%s_stall_cycles", tag), 64'(stalls), 64'(lat + 1));
    check_val($sformatf("%s_early_done", tag), 64'(early), 64'd0);
    @(negedge clk);
    check_val($sformatf("%s_done", tag), 64'(done), 64'd1);
    check_val($sformatf("%s_stall_off", tag), 64'(stallreq), 64'd0);
    check_val($sformatf("%s_hi", tag), 64'(hi), 64'(exp_hi));
    check_val($sformatf("%s_lo", tag), 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check_val($sformatf("%s_done_pulse", tag), 64'(done), 64'd0);
    check_val($sformatf("%s_hold", tag), {hi, lo}, {exp_hi, exp_lo});
    next_cycle();
  endtask

  // Run idle cycles and count any stall or done activity.
  task automatic quiet_window(input string tag, input int n);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (stallreq || done) act++;
    end
    check_val(tag, 64'(act), 64'd0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; start = 1'b0; op = 3'd0; src1 = '0; src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_val("reset_hi", 64'(hi), 64'd0);
    check_val("reset_lo", 64'(lo), 64'd0);
    check_val("reset_done", 64'(done), 64'd0);
    check_val("reset_stall", 64'(stallreq), 64'd0);
    next_cycle();

    run_md("mult_neg",   MULT,  32'hFFFF_FFFE, 32'd3,         32, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_md("multu",      MULTU, 32'hFFFF_FFFE, 32'd3,         32, 32'h0000_0002, 32'hFFFF_FFFA);
    run_md("multu_max",  MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("mult_minsq", MULT,  32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000, 32'h0000_0000);
    run_md("divu",       DIVU,  32'd100,       32'd7,         32, 32'd2,         32'd14);
    run_md("div_negn",   DIV,   32'hFFFF_FFF9, 32'd2,         32, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_negd",   DIV,   32'd7,         32'hFFFF_FFFE, 32, 32'd1,         32'hFFFF_FFFD);
    run_md("div_minint", DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32, 32'd0,         32'h8000_0000);
    run_md("divu_zero",  DIVU,  32'd5,         32'd0,          0, 32'd5,         32'hFFFF_FFFF);
    run_md("div_zero",   DIV,   32'hFFFF_FFF9, 32'd0,          0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // MTHI then MTLO back to back
    start = 1'b1; op = MTHI; src1 = 32'h1234;
    @(negedge clk);
    check_val("mthi_stall", 64'(stallreq), 64'd0);
    next_cycle();
    op = MTLO; src1 = 32'h5678;
    @(negedge clk);
    check_val("mthi_hi", 64'(hi), 64'h1234);
    check_val("mthi_lo_kept", 64'(lo), 64'hFFFF_FFFF);
    check_val("mtlo_stall", 64'(stallreq), 64'd0);
    next_cycle();
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    check_val("mtlo_lo", 64'(lo), 64'h5678);
    check_val("mtlo_hi_kept", 64'(hi), 64'h1234);
    next_cycle();

    // flush in IDLE blocks a same-cycle start
    start = 1'b1; flush = 1'b1; op = MTHI; src1 = 32'hDEAD;
    next_cycle();
    start = 1'b0; flush = 1'b0; op = 3'd0;
    @(negedge clk);
    check_val("idle_flush_hi", 64'(hi), 64'h1234);
    next_cycle();

    // flush a DIV in cycle 10 with a competing start
    start = 1'b1; op = DIV; src1 = 32'd100; src2 = 32'd7;
    next_cycle();
    start = 1'b0; op = 3'd0;
    repeat (9) next_cycle();
    @(negedge clk);
    check_val("flush_pre_stall", 64'(stallreq), 64'd1);
    flush = 1'b1; start = 1'b1; op = DIVU; src1 = 32'd9; src2 = 32'd3;
    next_cycle();
    flush = 1'b0; start = 1'b0; op = 3'd0;
    quiet_window("flush_quiet", 40);
    check_val("flush_hilo", {hi, lo}, {32'h1234, 32'h5678});

    // reset during cycle 15 of a MULT
    start = 1'b1; op = MULT; src1 = 32'd7; src2 = 32'd6;
    next_cycle();
    start = 1'b0; op = 3'd0;
    repeat (14) next_cycle();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_hilo", {hi, lo}, 64'd0);
    check_val("midrst_stall", 64'(stallreq), 64'd0);
    quiet_window("midrst_quiet", 40);
    next_cycle();

    run_md("mult_after_rst", MULT, 32'd7,         32'd6, 32, 32'd0,         32'd42);
    run_md("mult_b2b",       MULT, 32'hFFFF_FFFD, 32'd5, 32, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit, instantiated inside the EX stage of the 5-stage MIPS pipeline, next to the single-cycle ALU.
- Owns the architectural HI/LO registers.
- Executes MULT/MULTU/DIV/DIVU iteratively. While busy it raises a stall request into the central stall controller.
- Also executes MTHI/MTLO in a single cycle.
- Width is parametrised, so the same unit serves the 32-bit core and narrower test builds.

Parameters:
- DATA_W, 32: operand and HI/LO width; iteration count equals DATA_W.
- DIV0_QUOT, {DATA_W{1'b1}}: value written to LO on divide-by-zero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (rst==0 resets on the next posedge).
- flush  in  1  abort any in-flight operation (exception/branch squash).
- start  in  1  EX presents a valid mul/div/mt op this cycle.
- op  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- src1  in  DATA_W  rs value (multiplicand/dividend/MT source).
- src2  in  DATA_W  rt value (multiplier/divisor).
- stallreq  out  1  request to hold IF..EX.
- done  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- hi  out  DATA_W  current HI register.
- lo  out  DATA_W  current LO register.

Behaviour:
- States: IDLE, MUL, DIV, DONE. Iteration counter width is clog2(DATA_W)+1.

Reset (rst==0 at posedge):
- State goes to IDLE; hi=0, lo=0, done=0, counter=0.
- Reset takes priority over flush and start, including mid-operation.

Accept (IDLE, start=1):
- op 1-4: latch operand magnitudes. Signed ops take the absolute value, treating src as two's complement.
- Record the result sign flags.
- Go to MUL (op 1,2) or DIV (op 3,4); counter=0.
- op 5: hi<=src1 at this posedge. op 6: lo<=src1. State stays IDLE; stallreq is never asserted for op 5/6.
- op 0/7: no effect.

stallreq (combinational):
- stallreq = (state==IDLE & start & op in 1..4) | state==MUL | state==DIV.
- stallreq is 0 in DONE and in IDLE otherwise.
- Because stallreq is high in the accept cycle, the op is held in EX.

MUL:
- Radix-2 shift-add over the 2*DATA_W partial product, one bit per cycle.
- After DATA_W iterations go to DONE.

DIV:
- Radix-2 restoring division, one quotient bit per cycle.
- After DATA_W iterations go to DONE.

DONE (one cycle):
- Apply sign correction and write the result.
- MUL: {hi,lo} = 2*DATA_W product.
- DIV: lo = quotient, hi = remainder.
- Quotient is negated when the operand signs differ (signed only). Remainder takes the sign of the dividend.
- done=1 for this cycle only; the next state is IDLE.

Latency:
- Accept at cycle 0; stallreq high in cycles 0..DATA_W.
- hi/lo hold the new values and done=1 in cycle DATA_W+1.
- The held instruction leaves EX in cycle DATA_W+1.

Special cases:
- Divide by zero (src2==0, either div op): skip iteration; go to DONE the cycle after accept; hi=src1 (raw), lo=DIV0_QUOT. stallreq is high for exactly 1 cycle.
- Signed DIV of min-int by -1: lo=min-int, hi=0. This follows naturally from magnitude arithmetic; no trap.

flush:
- In MUL, DIV or DONE: return to IDLE next cycle; hi/lo unchanged; no done pulse.
- In IDLE: start is ignored in the same cycle.

Other rules:
- start while in MUL/DIV/DONE is ignored; the in-flight op is never replaced.
- hi/lo change only at accept of op 5/6, in DONE, or at reset.

Test Plan (DATA_W=32):
- MULT src1=0xFFFFFFFE, src2=3 -> stallreq high cycles 0..32; cycle 33: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIVU 100/7 -> lo=14, hi=2 at cycle 33. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> stallreq high 1 cycle; next cycle lo=0xFFFFFFFF, hi=5, done=1.
- MTHI src1=0x1234 -> hi=0x1234 after 1 posedge; stallreq stays 0; lo unchanged. A following MTLO 0x5678 in the next cycle -> lo=0x5678.
- Start DIV, assert flush in cycle 10 together with a new start -> IDLE after that edge; stallreq=0; no done; hi/lo keep prior values; the new start is not accepted.
- Drive rst=0 for one cycle during cycle 15 of a MULT -> hi=lo=0, stallreq=0, done never pulses. Back-to-back MULT issued after reset completes normally at 33 cycles.
